tagged_reg_file_mp: RTL and testbench
=====================================

Name: tagged_reg_file_mp

Overview:
- Multi-ported architectural register file with per-register rename tags for the out-of-order core. Successor to the single-issue tagged register file.
- Sits between decode/issue and the reservation stations.
- Supplies operand value or producing tag on each read port, records new producer tags on rename ports, and captures results from NUM_WB write-back (CDB) channels.
- Register 0 is hardwired to zero and is never tagged.

Parameters:
- NUM_REGS, 32, number of architectural registers (power of 2); AW = $clog2(NUM_REGS) is a localparam.
- DATA_W, 32, register data width.
- TAG_W, 4, instruction tag width; all-ones (TAG_INVALID) means "value ready, no pending producer".
- NUM_RD, 4, number of read ports (2 per issued instruction).
- NUM_RN, 2, number of rename ports; a higher index is later in program order.
- NUM_WB, 2, number of write-back channels.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; invalidates every tag.
- rd_en  in  NUM_RD  read request per port.
- rd_addr  in  NUM_RD*AW  read register index.
- rd_data  out  NUM_RD*DATA_W  registered read data.
- rd_tag  out  NUM_RD*TAG_W  registered producer tag (TAG_INVALID if ready).
- rd_ready  out  NUM_RD  registered; 1 when rd_tag == TAG_INVALID.
- rn_en  in  NUM_RN  rename request.
- rn_rd  in  NUM_RN*AW  destination register.
- rn_tag  in  NUM_RN*TAG_W  new producer tag; never TAG_INVALID.
- wb_valid  in  NUM_WB  write-back valid.
- wb_rd  in  NUM_WB*AW  write-back destination.
- wb_tag  in  NUM_WB*TAG_W  producing tag.
- wb_data  in  NUM_WB*DATA_W  result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All data = 0, all tags = TAG_INVALID.
  - rd_data = 0, rd_tag = TAG_INVALID, rd_ready = 1 on every port.
  - Reset mid-operation discards all pending renames.
- All state updates on posedge clk. Within one cycle, the order of effect is: write-back, then rename, then flush.
- Write-back, channel w:
  - Applies only if wb_valid[w], wb_rd != 0, and wb_tag[w] == current tag of reg[wb_rd].
  - When applied: data <= wb_data; tag <= TAG_INVALID.
  - A tag mismatch (stale producer, register re-renamed) is ignored silently.
  - Two channels carrying the same tag in one cycle is illegal; the bench asserts against it.
- Rename, port r:
  - If rn_en[r] and rn_rd != 0: tag of reg[rn_rd] <= rn_tag. Data is unchanged.
  - Two rename ports targeting the same register: the highest index wins.
  - Rename and a matching write-back to the same register in the same cycle: data takes wb_data and the tag takes rn_tag (rename overrides the invalidation).
  - Rename of reg 0 is ignored.
- Flush: all tags <= TAG_INVALID and pending renames in that cycle are dropped. Write-backs in the same cycle still update data.
- Read, port p:
  - Latency is 1 cycle. When rd_en[p], the outputs at the next edge reflect the register state at the start of the cycle, plus forwarding (see Optional Feature).
  - Reads never see same-cycle renames; intra-bundle dependencies are the decoder's responsibility.
  - rd_en low: outputs hold their previous values.
  - rd_addr == 0 always returns data 0, tag TAG_INVALID, ready 1.
- rd_ready is derived from the registered rd_tag only; there is no combinational input-to-output path.
- No backpressure. All ports are accepted every cycle.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- Defined: a read whose register, at the start of the cycle, holds a tag matched by a same-cycle valid write-back returns that wb_data, with rd_tag = TAG_INVALID and rd_ready = 1.
- Undefined: the read returns the pre-write-back data and the pending tag (rd_ready = 0). The consumer must then capture the value by snooping the CDB.
- Register state updates are identical in both builds.

Test Plan:
- Reset, then read regs 0, 5 and 31 on ports 0-2 -> one cycle later, data 0, tag 0xF, ready 1 on all ports.
- Rename r5 to tag 3; next cycle wb (r5, tag 3, 0xDEADBEEF); next cycle read r5 -> data 0xDEADBEEF, ready 1.
- Rename r5 to tag 3, then rename r5 to tag 7; wb (r5, tag 3, 0x11) -> ignored; read r5 -> tag 7, ready 0, data unchanged.
- Same cycle: rn port0 (r8, tag 2) and rn port1 (r8, tag 6) -> r8 tag = 6. Next, wb tag 2 on r8 -> ignored; wb tag 6 with 0x55 -> data 0x55, tag 0xF.
- r9 has tag 4. In one cycle: wb (r9, tag 4, 0xAA) plus read r9 -> with REGFILE_WB_FWD_EN: 0xAA, ready 1; without it: old data, tag 4, ready 0. Read again next cycle -> 0xAA, ready 1 in both builds.
- r3 has tag 1, r4 has tag 2. Assert flush in the same cycle as rename (r6, tag 5) and wb (r3, tag 1, 0x77) -> all tags 0xF, r3 = 0x77, r6 ready. Drop rst_n while r7 holds tag 5 -> r7 reads 0, ready 1.

Source files
------------

// File: rtl/tagged_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tagged_reg_file_mp
//   Multi-ported architectural register file with per-register rename tags.
//   Each read port returns either the operand value or the tag of its pending
//   producer. Rename ports record new producer tags. Write-back (CDB) channels
//   deliver results, and a result is accepted only when its tag still owns the
//   destination register. Register 0 reads as zero and is never tagged.
//
//   Within one clock the effects apply in this order: write-back, then rename,
//   then flush.
//
//   Optional build macro: REGFILE_WB_FWD_EN
//     defined   : a read of a register whose producer writes back in the same
//                 cycle returns the write-back data as ready.
//     undefined : that read returns the old data and the pending tag.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  drop every pending tag (synchronous)
//   rd_en/rd_addr          read request and register index, per port
//   rd_data/rd_tag         registered read value and producer tag, per port
//   rd_ready               1 when the registered rd_tag is TAG_INVALID
//   rn_en/rn_rd/rn_tag     rename request, destination and new producer tag
//   wb_valid/wb_rd/wb_tag/wb_data   write-back channels
// -----------------------------------------------------------------------------
module tagged_reg_file_mp #(
  parameter  int NUM_REGS = 32,
  parameter  int DATA_W   = 32,
  parameter  int TAG_W    = 4,
  parameter  int NUM_RD   = 4,
  parameter  int NUM_RN   = 2,
  parameter  int NUM_WB   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*AW-1:0]       rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD*TAG_W-1:0]    rd_tag,
  output logic [NUM_RD-1:0]          rd_ready,
  input  logic [NUM_RN-1:0]          rn_en,
  input  logic [NUM_RN*AW-1:0]       rn_rd,
  input  logic [NUM_RN*TAG_W-1:0]    rn_tag,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*AW-1:0]       wb_rd,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data
);

  localparam logic [TAG_W-1:0] TAG_INVALID = '1;

  // Architectural state
  logic [DATA_W-1:0] data_q [NUM_REGS];
  logic [TAG_W-1:0]  tag_q  [NUM_REGS];
  logic [DATA_W-1:0] data_d [NUM_REGS];
  logic [TAG_W-1:0]  tag_d  [NUM_REGS];

  // Read output registers
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic [TAG_W-1:0]  rd_tag_q  [NUM_RD];
  logic [DATA_W-1:0] rd_data_d [NUM_RD];
  logic [TAG_W-1:0]  rd_tag_d  [NUM_RD];

  // Unpacked views of the flat port buses
  logic [AW-1:0]     rd_addr_a [NUM_RD];
  logic [AW-1:0]     rn_rd_a   [NUM_RN];
  logic [TAG_W-1:0]  rn_tag_a  [NUM_RN];
  logic [AW-1:0]     wb_rd_a   [NUM_WB];
  logic [TAG_W-1:0]  wb_tag_a  [NUM_WB];
  logic [DATA_W-1:0] wb_data_a [NUM_WB];
  logic [NUM_WB-1:0] wb_hit;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_addr_a[p]                 = rd_addr[p*AW +: AW];
    assign rd_data[p*DATA_W +: DATA_W]  = rd_data_q[p];
    assign rd_tag[p*TAG_W +: TAG_W]     = rd_tag_q[p];
    assign rd_ready[p]                  = (rd_tag_q[p] == TAG_INVALID);
  end

  for (genvar r = 0; r < NUM_RN; r++) begin : g_rn
    assign rn_rd_a[r]  = rn_rd[r*AW +: AW];
    assign rn_tag_a[r] = rn_tag[r*TAG_W +: TAG_W];
  end

  // A write-back counts only if its tag still owns the destination register at
  // the start of the cycle; stale producers of re-renamed registers drop out.
  for (genvar w = 0; w < NUM_WB; w++) begin : g_wb
    assign wb_rd_a[w]   = wb_rd[w*AW +: AW];
    assign wb_tag_a[w]  = wb_tag[w*TAG_W +: TAG_W];
    assign wb_data_a[w] = wb_data[w*DATA_W +: DATA_W];
    assign wb_hit[w]    = wb_valid[w] && (wb_rd_a[w] != '0) &&
                          (wb_tag_a[w] == tag_q[wb_rd_a[w]]);
  end

  // Next architectural state: write-back, then rename, then flush.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    data_d = data_q;
    tag_d  = tag_q;
    for (int w = 0; w < NUM_WB; w++) begin
      if (wb_hit[w]) begin
        data_d[wb_rd_a[w]] = wb_data_a[w];
        tag_d[wb_rd_a[w]]  = TAG_INVALID;
      end
    end
    // Ascending order lets the later (higher-index) rename win a collision,
    // and lets a rename override a same-cycle write-back invalidation.
    for (int r = 0; r < NUM_RN; r++) begin
      if (rn_en[r] && (rn_rd_a[r] != '0)) begin
        tag_d[rn_rd_a[r]] = rn_tag_a[r];
      end
    end
    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_d[i] = TAG_INVALID;
      end
    end
  end

  // Read path: start-of-cycle state, optionally bypassing same-cycle results.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_d[p] = rd_data_q[p];
      rd_tag_d[p]  = rd_tag_q[p];
      if (rd_en[p]) begin
        if (rd_addr_a[p] == '0) begin
          rd_data_d[p] = '0;
          rd_tag_d[p]  = TAG_INVALID;
        end else begin
          rd_data_d[p] = data_q[rd_addr_a[p]];
          rd_tag_d[p]  = tag_q[rd_addr_a[p]];
`ifdef REGFILE_WB_FWD_EN
          for (int w = 0; w < NUM_WB; w++) begin
            if (wb_hit[w] && (wb_rd_a[w] == rd_addr_a[p])) begin
              rd_data_d[p] = wb_data_a[w];
              rd_tag_d[p]  = TAG_INVALID;
            end
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register array sits under the async reset because a reset
      // must read back as zero data with no pending producer.
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= TAG_INVALID;
      end
      for (int p = 0; p < NUM_RD; p++) begin
        rd_data_q[p] <= '0;
        rd_tag_q[p]  <= TAG_INVALID;
      end
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values regardless of statement order.
      data_q    <= data_d;
      tag_q     <= tag_d;
      rd_data_q <= rd_data_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

endmodule

// File: tb/tb_tagged_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_tagged_reg_file_mp
//   Scoreboard bench for tagged_reg_file_mp. The driver applies one bundle of
//   inputs per cycle, works out the expected read outputs from a register
//   array model, and queues them. A monitor pops and compares one entry per
//   read port after every rising edge.
// -----------------------------------------------------------------------------
module tb_tagged_reg_file_mp;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 4;
  localparam int NUM_RD   = 4;
  localparam int NUM_RN   = 2;
  localparam int NUM_WB   = 2;
  localparam int AW       = 5;
  localparam logic [TAG_W-1:0] TI = 4'hF;

  logic                     clk;
  logic                     rst_n;
  logic                     flush;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD*TAG_W-1:0]  rd_tag;
  logic [NUM_RD-1:0]        rd_ready;
  logic [NUM_RN-1:0]        rn_en;
  logic [NUM_RN*AW-1:0]     rn_rd;
  logic [NUM_RN*TAG_W-1:0]  rn_tag;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*AW-1:0]     wb_rd;
  logic [NUM_WB*TAG_W-1:0]  wb_tag;
  logic [NUM_WB*DATA_W-1:0] wb_data;

  tagged_reg_file_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_tag   (rd_tag),
    .rd_ready (rd_ready),
    .rn_en    (rn_en),
    .rn_rd    (rn_rd),
    .rn_tag   (rn_tag),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_tag   (wb_tag),
    .wb_data  (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int               port;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              ready;
  } exp_t;

  exp_t sb[$];
  bit   mon_en = 1'b0;

  // Reference model: register contents and the last value seen on each port.
  logic [DATA_W-1:0] m_data [NUM_REGS];
  logic [TAG_W-1:0]  m_tag  [NUM_REGS];
  logic [DATA_W-1:0] e_data [NUM_RD];
  logic [TAG_W-1:0]  e_tag  [NUM_RD];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_data[i] = '0;
      m_tag[i]  = TI;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      e_data[p] = '0;
      e_tag[p]  = TI;
    end
    sb.delete();
  endtask

  task automatic clear_inputs();
    flush = 0; rd_en = '0; rd_addr = '0; rn_en = '0; rn_rd = '0; rn_tag = '0;
    wb_valid = '0; wb_rd = '0; wb_tag = '0; wb_data = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_rn(input int r, input int a, input int t);
    rn_en[r] = 1'b1;
    rn_rd[r*AW +: AW] = AW'(a);
    rn_tag[r*TAG_W +: TAG_W] = TAG_W'(t);
  endtask

  task automatic set_wb(input int w, input int a, input int t, input logic [DATA_W-1:0] d);
    wb_valid[w] = 1'b1;
    wb_rd[w*AW +: AW] = AW'(a);
    wb_tag[w*TAG_W +: TAG_W] = TAG_W'(t);
    wb_data[w*DATA_W +: DATA_W] = d;
  endtask

  // Would this write-back channel land, judged against the model's current tags?
  function automatic bit wb_lands(input int w);
    logic [AW-1:0] a;
    a = wb_rd[w*AW +: AW];
    return wb_valid[w] && (a != 0) && (wb_tag[w*TAG_W +: TAG_W] == m_tag[a]);
  endfunction

  // Apply the current inputs for one clock: queue expected reads, advance model.
  task automatic cycle();
    logic [DATA_W-1:0] nd [NUM_REGS];
    logic [TAG_W-1:0]  nt [NUM_REGS];
    logic [AW-1:0]     a;
    assert (!(wb_valid == 2'b11 && wb_tag[TAG_W-1:0] == wb_tag[2*TAG_W-1:TAG_W]))
      else $error("illegal stimulus: two write-backs with one tag");
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_en[p]) begin
        a = rd_addr[p*AW +: AW];
        if (a == 0) begin
          e_data[p] = '0;
          e_tag[p]  = TI;
        end else begin
          e_data[p] = m_data[a];
          e_tag[p]  = m_tag[a];
`ifdef REGFILE_WB_FWD_EN
          for (int w = 0; w < NUM_WB; w++) begin
            if (wb_lands(w) && wb_rd[w*AW +: AW] == a) begin
              e_data[p] = wb_data[w*DATA_W +: DATA_W];
              e_tag[p]  = TI;
            end
          end
`endif
        end
      end
      sb.push_back('{p, e_data[p], e_tag[p], e_tag[p] == TI});
    end
    nd = m_data;
    nt = m_tag;
    for (int w = 0; w < NUM_WB; w++) begin
      if (wb_lands(w)) begin
        nd[wb_rd[w*AW +: AW]] = wb_data[w*DATA_W +: DATA_W];
        nt[wb_rd[w*AW +: AW]] = TI;
      end
    end
    for (int r = 0; r < NUM_RN; r++) begin
      if (rn_en[r] && rn_rd[r*AW +: AW] != 0) nt[rn_rd[r*AW +: AW]] = rn_tag[r*TAG_W +: TAG_W];
    end
    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) nt[i] = TI;
    end
    m_data = nd;
    m_tag  = nt;
    @(negedge clk);
    clear_inputs();
  endtask

  // Asynchronous reset, outputs checked while reset is held.
  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    for (int p = 0; p < NUM_RD; p++) begin
      check($sformatf("reset_data%0d", p), 64'(rd_data[p*DATA_W +: DATA_W]), 64'd0);
      check($sformatf("reset_tag%0d", p), 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(TI));
      check($sformatf("reset_ready%0d", p), 64'(rd_ready[p]), 64'd1);
    end
    model_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: outputs are refreshed every edge (held when rd_en is low).
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        for (int p = 0; p < NUM_RD; p++) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=entry");
          end else begin
            e = sb.pop_front();
            check($sformatf("rd%0d_data", e.port), 64'(rd_data[e.port*DATA_W +: DATA_W]), 64'(e.data));
            check($sformatf("rd%0d_tag", e.port), 64'(rd_tag[e.port*TAG_W +: TAG_W]), 64'(e.tag));
            check($sformatf("rd%0d_ready", e.port), 64'(rd_ready[e.port]), 64'(e.ready));
          end
        end
      end
    end
  end

  initial begin
    int a;
    rst_n = 1'b1;
    clear_inputs();
    #2;
    do_reset();

    // Reads of r0, r5, r31 straight after reset
    set_rd(0, 0); set_rd(1, 5); set_rd(2, 31); cycle();
    cycle();

    // Rename then matching write-back
    set_rn(0, 5, 3); cycle();
    set_wb(0, 5, 3, 32'hDEADBEEF); cycle();
    set_rd(0, 5); cycle();

    // Stale producer ignored after re-rename
    set_rn(0, 5, 3); cycle();
    set_rn(0, 5, 7); cycle();
    set_wb(0, 5, 3, 32'h11); cycle();
    set_rd(0, 5); cycle();

    // Same-cycle rename collision, higher port wins
    set_rn(0, 8, 2); set_rn(1, 8, 6); cycle();
    set_wb(0, 8, 2, 32'h99); cycle();
    set_rd(1, 8); cycle();
    set_wb(1, 8, 6, 32'h55); cycle();
    set_rd(2, 8); cycle();

    // Read during the producer's write-back
    set_rn(0, 9, 4); cycle();
    set_wb(0, 9, 4, 32'hAA); set_rd(0, 9); cycle();
    set_rd(0, 9); cycle();

    // Rename overriding a same-cycle write-back; rename of r0 ignored
    set_rn(0, 10, 1); cycle();
    set_wb(0, 10, 1, 32'h1234); set_rn(1, 10, 9); set_rn(0, 0, 3); cycle();
    set_rd(0, 10); set_rd(1, 0); cycle();

    // Flush with rename and write-back in the same cycle
    set_rn(0, 3, 1); set_rn(1, 4, 2); cycle();
    flush = 1'b1; set_rn(0, 6, 5); set_wb(0, 3, 1, 32'h77); cycle();
    set_rd(0, 3); set_rd(1, 4); set_rd(2, 6); cycle();

    // Reset with a pending rename
    set_rn(0, 7, 5); cycle();
    set_rd(3, 7); cycle();
    do_reset();
    set_rd(3, 7); set_rd(0, 5); cycle();

    // Randomized traffic over a small register window to force collisions
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < NUM_RD; p++) if ($urandom_range(1, 0) != 0) set_rd(p, $urandom_range(15, 0));
      for (int r = 0; r < NUM_RN; r++)
        if ($urandom_range(2, 0) == 0) set_rn(r, $urandom_range(15, 0), $urandom_range(14, 0));
      for (int w = 0; w < NUM_WB; w++) begin
        if ($urandom_range(1, 0) != 0) begin
          a = $urandom_range(15, 0);
          if ($urandom_range(3, 0) != 0 && m_tag[a] != TI)
            set_wb(w, a, int'(m_tag[a]), $urandom());
          else
            set_wb(w, a, $urandom_range(14, 0), $urandom());
        end
      end
      if (wb_valid == 2'b11 && wb_tag[TAG_W-1:0] == wb_tag[2*TAG_W-1:TAG_W]) wb_valid[1] = 1'b0;
      if ($urandom_range(31, 0) == 0) flush = 1'b1;
      cycle();
    end

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
